// File: rtl/score_render.sv
// score_render: renders the scaled 5x7 two-digit BCD score as a 2-cycle pipelined pixel stream.
module score_render #(
  parameter int H_TOT    = 800,
  parameter int V_TOT    = 525,
  parameter int X0       = 304,
  parameter int Y0       = 32,
  parameter int SCALE    = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [7:0]               iScore,
  input  logic [$clog2(H_TOT)-1:0] iHPos,
  input  logic [$clog2(V_TOT)-1:0] iVPos,
  input  logic                     iActive,
  input  logic                     iHSync,
  input  logic                     iVSync,
  output logic                     oPixOn,
  output logic                     oActive,
  output logic                     oHSync,
  output logic                     oVSync
);
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int SH = $clog2(SCALE);
  localparam int HM = H_TOT - 1;
  localparam int VM = V_TOT - 1;
  localparam int XE = X0 + 12 * SCALE;
  localparam int YE = Y0 + 7 * SCALE;
  localparam int UW = 6 * SCALE;
  localparam logic [HW-1:0] HLAST = HM[HW-1:0];
  localparam logic [VW-1:0] VLAST = VM[VW-1:0];
  localparam logic [HW:0] XL = X0[HW:0];
  localparam logic [HW:0] XH = XE[HW:0];
  localparam logic [HW:0] UX = UW[HW:0];
  localparam logic [VW:0] YL = Y0[VW:0];
  localparam logic [VW:0] YH = YE[VW:0];
  // Row 0 sits in the top 5 bits; nibbles A-F are all-zero glyphs.
  localparam logic [34:0] GLYPH [16] = '{
    {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
    {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
    {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
    {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
    {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
    {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
    {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
    {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
    {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
    {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C},
    35'h0, 35'h0, 35'h0, 35'h0, 35'h0, 35'h0
  };
  logic [7:0] rShown;
  logic [HW:0] hx, lx, lxp;
  logic [VW:0] vy, ly;
  logic inBox, units;
  logic [3:0] dig;
  logic s1InBox, s1Act, s1HSync, s1VSync;
  logic [3:0] s1Dig;
  logic [2:0] s1Row, s1Col;
  logic [5:0] sel;
  logic [4:0] pat;
  logic bitOn;
  always_comb begin
    hx = {1'b0, iHPos};
    vy = {1'b0, iVPos};
    lx = hx - XL;
    ly = vy - YL;
    inBox = hx >= XL && hx < XH && vy >= YL && vy < YH;
    units = lx >= UX;
    lxp = units ? lx - UX : lx;
    dig = units ? rShown[3:0] : (BLANK_LZ != 0 && rShown[7:4] == 4'h0) ? 4'hF : rShown[7:4];
  end
  always_comb begin
    sel = 6'd30 - 6'd5 * {3'b0, s1Row};
    pat = GLYPH[s1Dig][sel +: 5];
    bitOn = s1Col < 3'd5 ? pat[3'd4 - s1Col] : 1'b0;
  end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rShown  <= '0;
      s1InBox <= 1'b0;
      s1Dig   <= '0;
      s1Row   <= '0;
      s1Col   <= '0;
      s1Act   <= 1'b0;
      s1HSync <= 1'b1;
      s1VSync <= 1'b1;
      oPixOn  <= 1'b0;
      oActive <= 1'b0;
      oHSync  <= 1'b1;
      oVSync  <= 1'b1;
    end else begin
      rShown  <= (iHPos == HLAST && iVPos == VLAST) ? iScore : rShown;
      s1InBox <= inBox;
      s1Dig   <= dig;
      s1Row   <= inBox ? 3'(ly >> SH) : 3'd0;
      s1Col   <= inBox ? 3'(lxp >> SH) : 3'd0;
      s1Act   <= iActive;
      s1HSync <= iHSync;
      s1VSync <= iVSync;
      oPixOn  <= s1InBox & bitOn & s1Act;
      oActive <= s1Act;
      oHSync  <= s1HSync;
      oVSync  <= s1VSync;
    end
  end
endmodule

// File: tb/tb_score_render.sv
// tb_score_render: scoreboard bench; stimulus queues expected outputs, a monitor pops them two cycles later.
module tb_score_render;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] score;
  logic [9:0] h, v;
  logic act, hs, vs;
  logic pix, oAct, oHs, oVs, pix2, oAct2, oHs2, oVs2;
  always #5 clk = ~clk;

  score_render dut (
    .iClk(clk), .iRst(rst), .iScore(score), .iHPos(h), .iVPos(v),
    .iActive(act), .iHSync(hs), .iVSync(vs),
    .oPixOn(pix), .oActive(oAct), .oHSync(oHs), .oVSync(oVs)
  );
  score_render #(.X0(0), .Y0(0), .SCALE(1)) dut2 (
    .iClk(clk), .iRst(rst), .iScore(score), .iHPos(h), .iVPos(v),
    .iActive(act), .iHSync(hs), .iVSync(vs),
    .oPixOn(pix2), .oActive(oAct2), .oHSync(oHs2), .oVSync(oVs2)
  );

  typedef struct {
    int due;
    logic pix, act, hs, vs, chk2, pix2;
    string name;
  } exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, bad = 0;

  task automatic chk(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s_late due=%0d now=%0d", e.name, e.due, cyc);
      end
      chk({e.name, "_pix"}, pix, e.pix);
      chk({e.name, "_act"}, oAct, e.act);
      chk({e.name, "_hs"}, oHs, e.hs);
      chk({e.name, "_vs"}, oVs, e.vs);
      if (e.chk2) begin
        chk({e.name, "_pix2"}, pix2, e.pix2);
        chk({e.name, "_act2"}, oAct2, e.act);
      end
    end
  end

  task automatic drive(input string nm, input int x, input int y, input logic a,
                       input logic hsv, input logic vsv, input logic ep,
                       input logic c2, input logic ep2);
    @(negedge clk);
    h = 10'(x);
    v = 10'(y);
    act = a;
    hs = hsv;
    vs = vsv;
    q.push_back('{cyc + 2, ep, a, hsv, vsv, c2, ep2, nm});
  endtask

  task automatic px(input string nm, input int x, input int y, input logic ep);
    drive(nm, x, y, 1'b1, 1'b1, 1'b1, ep, 1'b0, 1'b0);
  endtask

  task automatic latch(input logic [7:0] s);
    score = s;
    drive("latch", 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 score = 8'hEE;
  endtask

  initial begin
    h = '0; v = '0; act = 1'b0; hs = 1'b1; vs = 1'b1; score = 8'h42;
    repeat (3) @(negedge clk);
    chk("rst_pix", pix, 1'b0);
    chk("rst_act", oAct, 1'b0);
    chk("rst_hs", oHs, 1'b1);
    chk("rst_vs", oVs, 1'b1);
    rst = 1'b0;
    latch(8'h42);
    px("d4_r0c3", 316, 32, 1'b1);
    px("d4_r0c0", 304, 32, 1'b0);
    for (int y = 56; y < 60; y += 3)
      for (int x = 328; x < 348; x++) px("d2_r6", x, y, 1'b1);
    for (int x = 348; x < 352; x++) px("gap", x, 56, 1'b0);
    px("x_edge", 352, 56, 1'b0);
    px("y_edge", 332, 60, 1'b0);
    px("x_low", 303, 32, 1'b0);
    px("y_low", 316, 31, 1'b0);
    score = 8'h57;
    px("mid_frame", 100, 200, 1'b0);
    px("old_tens", 304, 32, 1'b0);
    px("old_units", 328, 32, 1'b0);
    latch(8'h57);
    px("new_tens5", 304, 32, 1'b1);
    px("new_units7", 328, 32, 1'b1);
    latch(8'h07);
    for (int x = 304; x < 328; x++) px("lz_blank", x, 32, 1'b0);
    px("lz_units7", 328, 32, 1'b1);
    latch(8'h00);
    px("zero_units", 332, 32, 1'b1);
    px("zero_tens", 308, 32, 1'b0);
    latch(8'h3C);
    px("d3_tens", 304, 32, 1'b1);
    for (int y = 32; y < 60; y += 24)
      for (int x = 328; x < 348; x++) px("bcd_c_blank", x, y, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic a, hv, vv;
      int x;
      a = 1'($urandom_range(1));
      hv = 1'($urandom_range(1));
      vv = 1'($urandom_range(1));
      x = (i % 3 == 0) ? 400 : 316;
      drive("align", x, 32, a, hv, vv, (x == 316) & a, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) px("pre_rst_lit", 316, 32, 1'b1);
    repeat (2) @(negedge clk);
    chk("pre_rst_pix", pix, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pix", pix, 1'b0);
    chk("async_rst_act", oAct, 1'b0);
    chk("async_rst_hs", oHs, 1'b1);
    chk("async_rst_vs", oVs, 1'b1);
    chk("async_rst_hs2", oHs2, 1'b1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    px("post_rst_units0", 332, 32, 1'b1);
    px("post_rst_tens", 304, 32, 1'b0);
    latch(8'h01);
    drive("s1_c0", 6, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive("s1_c2", 8, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive("s1_r6", 8, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive("s1_xedge", 12, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive("s1_yedge", 8, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive("s1_gap", 11, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
